// File: rtl/rom_dl_sequencer_if.sv
// Host download bus (ioctl) between the HPS bridge and rom_dl_sequencer.
// master = host side (drives the byte stream), slave = sequencer side.
`timescale 1ns/1ps
interface rom_dl_sequencer_if;
  // Handshake: ioctl_wr is a one-cycle strobe qualifying ioctl_addr/ioctl_dout.
  // ioctl_wait is the inverse of ready: while it is high the host must not
  // strobe ioctl_wr; a strobe that arrives while ioctl_wait is high is
  // discarded by the slave and flagged as an error.
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  modport master (
    output ioctl_download,
    output ioctl_index,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download,
    input  ioctl_index,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    output ioctl_wait
  );
endinterface

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: routes the index-0 ROM download into the MCR3 memory map
// (main CPU BRAM, sound ROM on SDRAM port1, sprite ROM on SDRAM port2, BG
// BRAM), throttles the host while an SDRAM toggle request is outstanding,
// and owns rom_loaded / core_reset for the whole core.
// Optional feature: define DL_CHECKSUM_EN to enable the dl_count/dl_sum
// byte counter and additive checksum; otherwise both outputs are tied to 0.
`timescale 1ns/1ps
module rom_dl_sequencer #(
  parameter logic [24:0] SND_BASE    = 25'h0E000,
  parameter logic [24:0] SP_BASE     = 25'h12000,
  parameter logic [24:0] BG_BASE     = 25'h32000,
  parameter logic [24:0] ROM_END     = 25'h3A000,
  parameter logic [15:0] RST_HOLD    = 16'hFFFF,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd200
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  rom_dl_sequencer_if.slave ioctl,
  input  logic        user_reset,
  output logic        cpu_we,
  output logic [15:0] cpu_addr,
  output logic        bg_we,
  output logic [14:0] bg_addr,
  output logic [7:0]  dl_data,
  output logic        p1_req,
  input  logic        p1_ack,
  output logic [22:0] p1_a,
  output logic [1:0]  p1_ds,
  output logic        p2_req,
  input  logic        p2_ack,
  output logic [17:0] p2_a,
  output logic [1:0]  p2_ds,
  output logic [15:0] p_d,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        dl_err,
  output logic [23:0] dl_count,
  output logic [15:0] dl_sum,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic        wait_q;
  logic        sel_p2;       // which SDRAM port the outstanding request uses
  logic [7:0]  to_cnt;
  logic        rom_dl, rom_dl_q, dl_fall;
  logic        end_pend;
  logic        load_done;
  logic [15:0] rst_cnt;

  logic        hit_cpu, hit_p1, hit_p2, hit_bg;
  logic        wr_ok, busy_wr;
  logic        acc_cpu, acc_p1, acc_p2, acc_bg;
  logic [24:0] sp_off, bg_off;
  logic        ack_match;

  // FSM output-comb controls
  logic        wait_nxt, tog_p1, tog_p2, to_clr, to_inc, tmo;

  logic        unused_bits;

  assign ioctl.ioctl_wait = wait_q;
  assign fsm_state        = state;

  assign rom_dl  = ioctl.ioctl_download & (ioctl.ioctl_index == 8'd0);
  assign dl_fall = rom_dl_q & ~rom_dl;

  // A strobe is only taken when idle; in ISSUE/WAIT_ACK wait_q is always high.
  assign wr_ok   = rom_dl & ioctl.ioctl_wr & ~wait_q & (state == S_IDLE);
  assign busy_wr = rom_dl & ioctl.ioctl_wr & wait_q;

  assign hit_cpu = (ioctl.ioctl_addr <  SND_BASE);
  assign hit_p1  = (ioctl.ioctl_addr >= SND_BASE) & (ioctl.ioctl_addr < SP_BASE);
  assign hit_p2  = (ioctl.ioctl_addr >= SP_BASE)  & (ioctl.ioctl_addr < BG_BASE);
  assign hit_bg  = (ioctl.ioctl_addr >= BG_BASE)  & (ioctl.ioctl_addr < ROM_END);

  assign acc_cpu = wr_ok & hit_cpu;
  assign acc_p1  = wr_ok & hit_p1;
  assign acc_p2  = wr_ok & hit_p2;
  assign acc_bg  = wr_ok & hit_bg;

  // Offsets are only consumed when the address is inside the region.
  assign sp_off  = ioctl.ioctl_addr - SP_BASE;
  assign bg_off  = ioctl.ioctl_addr - BG_BASE;

  assign ack_match = sel_p2 ? (p2_ack == p2_req) : (p1_ack == p1_req);

  assign unused_bits = ^{sp_off[24:19], bg_off[24:15]};

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (acc_p1 | acc_p2) state_nxt = S_ISSUE;
      S_ISSUE:    state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (ack_match || (to_cnt == ACK_TIMEOUT - 8'd1)) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: next value of ioctl_wait, request toggles, timeout control
  always_comb begin
    wait_nxt = 1'b0;
    tog_p1   = 1'b0;
    tog_p2   = 1'b0;
    to_clr   = 1'b0;
    to_inc   = 1'b0;
    tmo      = 1'b0;
    case (state)
      S_IDLE: wait_nxt = acc_p1 | acc_p2;
      S_ISSUE: begin
        wait_nxt = 1'b1;
        tog_p1   = ~sel_p2;
        tog_p2   = sel_p2;
        to_clr   = 1'b1;
      end
      S_WAIT_ACK: begin
        if (ack_match) begin
          wait_nxt = 1'b0;
        end else if (to_cnt == ACK_TIMEOUT - 8'd1) begin
          tmo      = 1'b1;
        end else begin
          wait_nxt = 1'b1;
          to_inc   = 1'b1;
        end
      end
      default: wait_nxt = 1'b0;
    endcase
  end

  // Byte capture into the selected destination's address/data registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_we   <= 1'b0;
      bg_we    <= 1'b0;
      cpu_addr <= '0;
      bg_addr  <= '0;
      dl_data  <= '0;
      p1_a     <= '0;
      p1_ds    <= '0;
      p2_a     <= '0;
      p2_ds    <= '0;
      p_d      <= '0;
      sel_p2   <= 1'b0;
    end else begin
      cpu_we <= acc_cpu;
      bg_we  <= acc_bg;
      if (acc_cpu) begin
        cpu_addr <= ioctl.ioctl_addr[15:0];
        dl_data  <= ioctl.ioctl_dout;
      end
      if (acc_bg) begin
        bg_addr  <= bg_off[14:0];
        dl_data  <= ioctl.ioctl_dout;
      end
      if (acc_p1) begin
        p1_a   <= ioctl.ioctl_addr[23:1];
        p1_ds  <= {ioctl.ioctl_addr[0], ~ioctl.ioctl_addr[0]};
        p_d    <= {ioctl.ioctl_dout, ioctl.ioctl_dout};
        sel_p2 <= 1'b0;
      end
      if (acc_p2) begin
        p2_a   <= {sp_off[18:17], sp_off[14:0], sp_off[16]};
        p2_ds  <= {sp_off[15], ~sp_off[15]};
        p_d    <= {ioctl.ioctl_dout, ioctl.ioctl_dout};
        sel_p2 <= 1'b1;
      end
    end
  end

  // Toggle requests, host throttle, ack timeout and sticky error
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_req <= 1'b0;
      p2_req <= 1'b0;
      wait_q <= 1'b0;
      to_cnt <= '0;
      dl_err <= 1'b0;
    end else begin
      p1_req <= p1_req ^ tog_p1;
      p2_req <= p2_req ^ tog_p2;
      wait_q <= wait_nxt;
      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + 8'd1;
      dl_err <= dl_err | tmo | busy_wr;
    end
  end

  // rom_loaded: set when the download ends and no SDRAM write is outstanding
  assign load_done = (dl_fall | end_pend) & (state == S_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_dl_q   <= 1'b0;
      end_pend   <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      rom_dl_q   <= rom_dl;
      end_pend   <= (end_pend | dl_fall) & ~load_done;
      rom_loaded <= rom_loaded | load_done;
    end
  end

  // Core reset: held during download/until loaded, plus a late 1-cycle pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt    <= RST_HOLD;
      core_reset <= 1'b1;
    end else begin
      if (user_reset | ~rom_loaded) rst_cnt <= RST_HOLD;
      else if (rst_cnt != 16'd0)    rst_cnt <= rst_cnt - 16'd1;
      core_reset <= user_reset | rom_dl | ~rom_loaded | (rst_cnt == 16'd1);
    end
  end

`ifdef DL_CHECKSUM_EN
  logic dl_rise;
  logic acc_any;

  assign dl_rise = rom_dl & ~rom_dl_q;
  assign acc_any = acc_cpu | acc_p1 | acc_p2 | acc_bg;

  // Byte count and additive checksum of the current download
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_count <= '0;
      dl_sum   <= '0;
    end else if (dl_rise) begin
      dl_count <= '0;
      dl_sum   <= '0;
    end else if (acc_any) begin
      dl_count <= dl_count + 24'd1;
      dl_sum   <= dl_sum + {8'd0, ioctl.ioctl_dout};
    end
  end
`else
  assign dl_count = '0;
  assign dl_sum   = '0;
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: region decode, SDRAM toggle
// handshake, ack timeout, busy-write error, rom_loaded / core_reset timing,
// asynchronous reset abort and (when enabled) the download checksum.
`timescale 1ns/1ps
module tb_rom_dl_sequencer;

  // Clock / reset
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n;
  logic        user_reset;
  logic        p1_ack, p2_ack;
  logic        cpu_we, bg_we;
  logic [15:0] cpu_addr;
  logic [14:0] bg_addr;
  logic [7:0]  dl_data;
  logic        p1_req, p2_req;
  logic [22:0] p1_a;
  logic [1:0]  p1_ds, p2_ds;
  logic [17:0] p2_a;
  logic [15:0] p_d;
  logic        rom_loaded, core_reset, dl_err;
  logic [23:0] dl_count;
  logic [15:0] dl_sum;
  logic [1:0]  fsm_state;

  rom_dl_sequencer_if ioctl ();

  rom_dl_sequencer dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ioctl      (ioctl.slave),
    .user_reset (user_reset),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .bg_we      (bg_we),
    .bg_addr    (bg_addr),
    .dl_data    (dl_data),
    .p1_req     (p1_req),
    .p1_ack     (p1_ack),
    .p1_a       (p1_a),
    .p1_ds      (p1_ds),
    .p2_req     (p2_req),
    .p2_ack     (p2_ack),
    .p2_a       (p2_a),
    .p2_ds      (p2_ds),
    .p_d        (p_d),
    .rom_loaded (rom_loaded),
    .core_reset (core_reset),
    .dl_err     (dl_err),
    .dl_count   (dl_count),
    .dl_sum     (dl_sum),
    .fsm_state  (fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  // Driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl.ioctl_addr = addr;
    ioctl.ioctl_dout = data;
    ioctl.ioctl_wr   = 1'b1;
    tick();
    ioctl.ioctl_wr   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Global watchdog
  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n              = 1'b0;
    user_reset           = 1'b0;
    p1_ack               = 1'b0;
    p2_ack               = 1'b0;
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_index    = 8'd0;
    ioctl.ioctl_wr       = 1'b0;
    ioctl.ioctl_addr     = '0;
    ioctl.ioctl_dout     = '0;

    // Reset values
    #12;
    chk("rst_cpu_we",     cpu_we, 0);
    chk("rst_wait",       ioctl.ioctl_wait, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_dl_err",     dl_err, 0);
    chk("rst_reqs",       {p1_req, p2_req}, 0);
    chk("rst_fsm",        fsm_state, 0);
    chk("rst_p_d",        p_d, 0);
    #10 reset_n = 1'b1;
    tick();

    // Non-zero index is ignored
    ioctl.ioctl_download = 1'b1;
    ioctl.ioctl_index    = 8'd1;
    wr_byte(25'h01000, 8'h99);
    chk("idx1_cpu_we", cpu_we, 0);
    ioctl.ioctl_index = 8'd0;
    tick();
    chk("dl_core_reset", core_reset, 1);

    // CPU region write, latency 1
    wr_byte(25'h01234, 8'hA5);
    chk("cpu_we",    cpu_we, 1);
    chk("cpu_addr",  cpu_addr, 16'h1234);
    chk("cpu_data",  dl_data, 8'hA5);
    chk("cpu_wait",  ioctl.ioctl_wait, 0);
    tick();
    chk("cpu_we_pulse", cpu_we, 0);
    chk("cpu_wait2",    ioctl.ioctl_wait, 0);

    // Region boundaries
    wr_byte(25'h0DFFF, 8'h01);
    chk("cpu_top_we",   cpu_we, 1);
    chk("cpu_top_addr", cpu_addr, 16'hDFFF);
    wr_byte(25'h32010, 8'h77);
    chk("bg_we",        bg_we, 1);
    chk("bg_cpu_we",    cpu_we, 0);
    chk("bg_addr",      bg_addr, 15'h0010);
    chk("bg_data",      dl_data, 8'h77);
    wr_byte(25'h39FFF, 8'h78);
    chk("bg_top_addr",  bg_addr, 15'h7FFF);
    wr_byte(25'h3A000, 8'h79);
    chk("drop_we",      {cpu_we, bg_we}, 0);
    chk("drop_wait",    ioctl.ioctl_wait, 0);
    chk("drop_fsm",     fsm_state, 0);

    // Port1 write with ack 5 cycles after the toggle
    wr_byte(25'h0E003, 8'h5A);
    chk("p1_fsm_issue", fsm_state, 1);
    chk("p1_wait",      ioctl.ioctl_wait, 1);
    chk("p1_a",         p1_a, 23'h007001);
    chk("p1_ds",        p1_ds, 2'b10);
    chk("p1_p_d",       p_d, 16'h5A5A);
    chk("p1_req_pre",   p1_req, 0);
    tick();
    chk("p1_req_tog",   p1_req, 1);
    chk("p1_p2_quiet",  p2_req, 0);
    chk("p1_fsm_wait",  fsm_state, 2);
    repeat (4) tick();
    chk("p1_wait_hold", ioctl.ioctl_wait, 1);
    p1_ack = 1'b1;
    tick();
    chk("p1_wait_rel",  ioctl.ioctl_wait, 0);
    chk("p1_fsm_idle",  fsm_state, 0);

    // Port2 write, ack withheld -> timeout after 200 cycles
    wr_byte(25'h2A001, 8'hC3);
    chk("p2_a",         p2_a, 18'h00003);
    chk("p2_ds",        p2_ds, 2'b10);
    chk("p2_p_d",       p_d, 16'hC3C3);
    tick();
    chk("p2_req_tog",   p2_req, 1);
    chk("p2_p1_quiet",  p1_req, 1);
    repeat (199) tick();
    chk("to_wait_hold", ioctl.ioctl_wait, 1);
    chk("to_err_early", dl_err, 0);
    tick();
    chk("to_err",       dl_err, 1);
    chk("to_wait",      ioctl.ioctl_wait, 0);
    chk("to_fsm",       fsm_state, 0);
    chk("to_req_kept",  p2_req, 1);
    p2_ack = 1'b1;
    tick();

    // Download ends while a port2 write waits for its ack
    wr_byte(25'h12000, 8'h11);
    chk("p2b_a",        p2_a, 18'h00000);
    chk("p2b_ds",       p2_ds, 2'b01);
    tick();
    chk("p2b_req",      p2_req, 0);
    ioctl.ioctl_download = 1'b0;
    tick();
    tick();
    chk("end_loaded_hold", rom_loaded, 0);
    chk("end_core_hold",   core_reset, 1);
    chk("end_wait_hold",   ioctl.ioctl_wait, 1);
    p2_ack = 1'b0;
    tick();
    chk("end_ack_idle",    fsm_state, 0);
    chk("end_ack_loaded",  rom_loaded, 0);
    tick();
    chk("end_loaded",      rom_loaded, 1);
    chk("end_core_still",  core_reset, 1);
    tick();
    chk("end_core_fall",   core_reset, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (core_reset !== 1'b1 && n < 70000);
    chk("pulse_gap",       n, 65534);
    tick();
    chk("pulse_width",     core_reset, 0);
    chk("err_sticky",      dl_err, 1);

    // Asynchronous reset during WAIT_ACK
    ioctl.ioctl_download = 1'b1;
    tick();
    wr_byte(25'h12002, 8'h22);
    tick();
    chk("ar_req_pre",  p2_req, 1);
    chk("ar_fsm_pre",  fsm_state, 2);
    #2 reset_n = 1'b0;
    #1;
    p1_ack = 1'b0;
    p2_ack = 1'b0;
    chk("ar_fsm",      fsm_state, 0);
    chk("ar_reqs",     {p1_req, p2_req}, 0);
    chk("ar_wait",     ioctl.ioctl_wait, 0);
    chk("ar_loaded",   rom_loaded, 0);
    chk("ar_err",      dl_err, 0);
    chk("ar_core",     core_reset, 1);
    chk("ar_p_d",      p_d, 0);
    chk("ar_p2_a",     p2_a, 0);
    #2 reset_n = 1'b1;
    tick();
    wr_byte(25'h0E002, 8'h33);
    chk("ar2_p1_a",    p1_a, 23'h007001);
    chk("ar2_p1_ds",   p1_ds, 2'b01);
    chk("ar2_p_d",     p_d, 16'h3333);
    tick();
    chk("ar2_req",     p1_req, 1);
    tick();
    tick();
    p1_ack = 1'b1;
    tick();
    chk("ar2_wait",    ioctl.ioctl_wait, 0);
    chk("ar2_err",     dl_err, 0);

    // Strobe while ioctl_wait is high: dropped and flagged
    wr_byte(25'h0E004, 8'h55);
    chk("busy_wait",   ioctl.ioctl_wait, 1);
    wr_byte(25'h00100, 8'h66);
    chk("busy_err",    dl_err, 1);
    chk("busy_cpu_we", cpu_we, 0);
    p1_ack = 1'b0;
    tick();
    chk("busy_done",   ioctl.ioctl_wait, 0);

    // Checksum over a fresh download
    ioctl.ioctl_download = 1'b0;
    tick();
    ioctl.ioctl_download = 1'b1;
    tick();
`ifdef DL_CHECKSUM_EN
    chk("cks_clr_cnt", dl_count, 0);
    chk("cks_clr_sum", dl_sum, 0);
`endif
    wr_byte(25'h00010, 8'h01);
    wr_byte(25'h00011, 8'hFF);
    wr_byte(25'h3B000, 8'h40);
    wr_byte(25'h00012, 8'h10);
`ifdef DL_CHECKSUM_EN
    chk("cks_cnt",     dl_count, 3);
    chk("cks_sum",     dl_sum, 16'h0110);
    ioctl.ioctl_download = 1'b0;
    tick();
    ioctl.ioctl_download = 1'b1;
    tick();
    chk("cks_rst_cnt", dl_count, 0);
    chk("cks_rst_sum", dl_sum, 0);
`else
    chk("cks_off_cnt", dl_count, 0);
    chk("cks_off_sum", dl_sum, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
